// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS fetch front end:
//   - state_t : program-counter sequencer states (BOOT, RUN, EXC)
//   - sel_t   : next-PC source encoding used by the priority selector
//   - default reset / exception vectors
//   - is_misaligned(): word-alignment test for control-transfer targets
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_EXC  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_J    = 3'd2,
        SEL_JR   = 3'd3,
        SEL_TRAP = 3'd4
    } sel_t;

    // Instruction fetch addresses must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
// Combinational next-PC priority selector with target alignment check.
// Priority: trap > JR > J > taken branch > sequential.
// Only the transfer that would actually be taken is alignment-checked, so a
// misaligned jump_target is harmless when jump_reg wins the same cycle.
//
// Ports:
//   pc_plus4      in  32  current pc + 4
//   jump          in   1  J/JAL this cycle
//   jump_target   in  28  {instr_index, 2'b00}
//   branch_taken  in   1  resolved taken branch
//   branch_offset in  32  sign-extended, pre-shifted offset
//   jump_reg      in   1  JR/JALR this cycle
//   reg_target    in  32  rs operand
//   next_pc       out 32  selected next fetch address
//   trap          out  1  selected target is misaligned
// -----------------------------------------------------------------------------
module pc_next_mux
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic [27:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] next_pc,
    output logic        trap
);

    sel_t w_sel;

    always_comb begin
        w_sel = SEL_SEQ;
        if (jump_reg) begin
            w_sel = is_misaligned(reg_target[1:0]) ? SEL_TRAP : SEL_JR;
        end else if (jump) begin
            w_sel = is_misaligned(jump_target[1:0]) ? SEL_TRAP : SEL_J;
        end else if (branch_taken) begin
            // Offset is pre-shifted, so a branch target is always aligned.
            w_sel = SEL_BR;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (w_sel)
            SEL_TRAP: next_pc = EXC_VECTOR;
            SEL_JR:   next_pc = reg_target;
            SEL_J:    next_pc = {pc_plus4[31:28], jump_target};
            SEL_BR:   next_pc = pc_plus4 + branch_offset;
            default:  next_pc = pc_plus4;
        endcase
    end

    assign trap = (w_sel == SEL_TRAP);

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter register and fetch FSM for the MIPS core. Holds the PC,
// honours instruction-memory stall, and on a misaligned JR/J target records
// the faulting PC in epc and redirects to the exception vector.
//
// FSM: BOOT (one non-fetch cycle after reset) -> RUN; a trap moves RUN -> EXC
// (one non-fetch cycle at the vector) -> RUN. BOOT and EXC ignore stall and
// all control inputs; the PC is held through both.
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst_n         in   1  asynchronous active-low reset
//   stall         in   1  hold PC and all state
//   jump          in   1  J/JAL
//   jump_target   in  28  {instr_index, 2'b00}
//   branch_taken  in   1  taken branch
//   branch_offset in  32  sign-extended offset << 2
//   jump_reg      in   1  JR/JALR
//   reg_target    in  32  rs operand
//   pc            out 32  current fetch address
//   pc_plus4      out 32  pc + 4
//   fetch_valid   out  1  pc is a real fetch address
//   epc           out 32  pc of last faulting instruction
//   addr_err      out  1  one-cycle trap pulse
// -----------------------------------------------------------------------------
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump,
    input  logic [27:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic [31:0] epc,
    output logic        addr_err
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_addr_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_trap;
    logic        w_advance;

    // Natural 32-bit wrap takes 32'hFFFF_FFFC to 0.
    assign w_pc_plus4 = r_pc + 32'd4;

    pc_next_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .pc_plus4      (w_pc_plus4),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target),
        .next_pc       (w_next_pc),
        .trap          (w_trap)
    );

    // Only RUN with stall low consumes control inputs; a trap seen under
    // stall is simply re-evaluated once stall drops.
    assign w_advance = (r_state == ST_RUN) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_epc      <= 32'h0000_0000;
            r_addr_err <= 1'b0;
        end else begin
            // Pulse only on the edge that takes the trap.
            r_addr_err <= w_advance && w_trap;
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_EXC:  r_state <= ST_RUN;
                ST_RUN: begin
                    if (!stall) begin
                        r_pc <= w_next_pc;
                        if (w_trap) begin
                            r_epc   <= r_pc;
                            r_state <= ST_EXC;
                        end
                    end
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_valid = (r_state == ST_RUN);
    assign epc         = r_epc;
    assign addr_err    = r_addr_err;

endmodule
